apb_master_arbiter: RTL and testbench

Shares the single APB master port between up to four on-chip requesters, such as the core data path and a DMA/debug engine. It uses round-robin arbitration and runs the two-phase APB SETUP/ACCESS sequence itself. It sits upstream of the APB peripheral decode, which still selects UART, Timer, PMU, GPIO, STimer, CLKGEN and SMPU by `paddr`. Each requester sees a simple request/accept/response handshake and is isolated from APB wait states.

---
 rtl/apb_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NREQ requesters and runs SETUP/ACCESS itself.
// Optional ACCESS-phase watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          paddr,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic                 psel,
  output logic                 penable,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int GW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;

  logic              grant_found;
  logic [GW-1:0]     grant_idx;
  logic              accept;
  logic              done;
  logic              forced;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = GW'((int'(last_grant_q) + k) % NREQ);
      end
    end
  end

  assign accept    = (state_q == IDLE) && grant_found;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A late pready on the limit cycle still wins over the forced completion.
  assign forced = (state_q == ACCESS) && !pready && (wait_cnt_q == 8'(TIMEOUT - 1));
`else
  assign forced = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (pready || forced);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d       = (state_d == SETUP) || (state_d == ACCESS);
    penable_d    = (state_d == ACCESS);
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    if (accept) begin
      paddr_d      = req_addr[32*int'(grant_idx) +: 32];
      pwrite_d     = req_write[grant_idx];
      pwdata_d     = req_wdata[32*int'(grant_idx) +: 32];
      last_grant_d = grant_idx;
    end
    // Writes and forced completions report zero read data.
    if (done) begin
      rsp_valid_d = NREQ'(1) << last_grant_q;
      rsp_rdata_d = (forced || pwrite_q) ? 32'h0 : prdata;
      rsp_err_d   = forced ? 1'b1 : pslverr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= GW'(NREQ - 1);
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: cycle table plus wait-state, timeout and reset sequences.
// Timeout expectations follow APB_ARB_TIMEOUT_EN when it is defined for the build.
module tb_apb_master_arbiter;

  localparam logic [31:0] A0 = 32'h40013004;
  localparam logic [31:0] A1 = 32'h40011000;
  localparam logic [31:0] W0 = 32'h000000A5;
  localparam logic [31:0] W1 = 32'h0BADF00D;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  valid;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic [1:0]  expReady;
    logic [1:0]  expRspValid;
    logic        expPsel;
    logic        expPenable;
    logic        expErr;
    logic [31:0] expRdata;
    logic [31:0] expPaddr;
    logic        expPwrite;
    logic [31:0] expPwdata;
  } vec_t;

  vec_t vecs [21];

  apb_master_arbiter #(.NREQ(2), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic pr, input logic se, input logic [31:0] rd);
    req_valid = v;
    pready    = pr;
    pslverr   = se;
    prdata    = rd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_addr  = {A1, A0};
    req_wdata = {W1, W0};
    req_write = 2'b01;
    req_valid = 2'b00;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;
    rstn      = 1'b0;

    vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0};
    vecs[2]  = '{2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0,        A0,    1'b1, W0};
    vecs[3]  = '{2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        A0,    1'b1, W0};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,        A0,    1'b1, W0};
    vecs[5]  = '{2'b10, 1'b0, 1'b0, 32'h0,        2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        A0,    1'b1, W0};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0,        A1,    1'b0, W1};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        A1,    1'b0, W1};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        A1,    1'b0, W1};
    vecs[9]  = '{2'b00, 1'b1, 1'b0, 32'h12345678, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        A1,    1'b0, W1};
    vecs[10] = '{2'b11, 1'b0, 1'b0, 32'h0,        2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 32'h12345678, A1,    1'b0, W1};
    vecs[11] = '{2'b11, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h12345678, A0,    1'b1, W0};
    vecs[12] = '{2'b11, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h12345678, A0,    1'b1, W0};
    vecs[13] = '{2'b11, 1'b0, 1'b0, 32'h0,        2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0,        A0,    1'b1, W0};
    vecs[14] = '{2'b11, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,        A1,    1'b0, W1};
    vecs[15] = '{2'b11, 1'b1, 1'b0, 32'hCAFEF00D, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0,        A1,    1'b0, W1};
    vecs[16] = '{2'b11, 1'b0, 1'b0, 32'h0,        2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, A1,    1'b0, W1};
    vecs[17] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, A0,    1'b1, W0};
    vecs[18] = '{2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, A0,    1'b1, W0};
    vecs[19] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,        A0,    1'b1, W0};
    vecs[20] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        A0,    1'b1, W0};

    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single write, waited read, round robin with back-to-back grants and a slave error.
    for (int i = 0; i < 21; i++) begin
      cycle();
      applyStimulus(vecs[i].valid, vecs[i].pready, vecs[i].pslverr, vecs[i].prdata);
      checkOutput($sformatf("row%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("row%0d.rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].expRspValid));
      checkOutput($sformatf("row%0d.psel", i),      32'(psel),      32'(vecs[i].expPsel));
      checkOutput($sformatf("row%0d.penable", i),   32'(penable),   32'(vecs[i].expPenable));
      checkOutput($sformatf("row%0d.rsp_err", i),   32'(rsp_err),   32'(vecs[i].expErr));
      checkOutput($sformatf("row%0d.rsp_rdata", i), rsp_rdata,      vecs[i].expRdata);
      checkOutput($sformatf("row%0d.paddr", i),     paddr,          vecs[i].expPaddr);
      checkOutput($sformatf("row%0d.pwrite", i),    32'(pwrite),    32'(vecs[i].expPwrite));
      checkOutput($sformatf("row%0d.pwdata", i),    pwdata,         vecs[i].expPwdata);
    end

    // Requester 1 read with pready held low in ACCESS.
    cycle();
    applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
    checkOutput("stall.req_ready", 32'(req_ready), 32'h2);
    cycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("stall.setup_psel", 32'(psel), 32'h1);
    checkOutput("stall.setup_penable", 32'(penable), 32'h0);
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      cycle();
      applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("timeout.access%0d.penable", k), 32'(penable), 32'h1);
      checkOutput($sformatf("timeout.access%0d.rsp_valid", k), 32'(rsp_valid), 32'h0);
    end
    cycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("timeout.rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("timeout.rsp_err", 32'(rsp_err), 32'h1);
    checkOutput("timeout.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("timeout.psel", 32'(psel), 32'h0);
`else
    for (int k = 0; k < 100; k++) begin
      cycle();
      applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("stall.access%0d.penable", k), 32'(penable), 32'h1);
      checkOutput($sformatf("stall.access%0d.rsp_valid", k), 32'(rsp_valid), 32'h0);
    end
    cycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h55AA55AA);
    checkOutput("stall.final_penable", 32'(penable), 32'h1);
    cycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("stall.rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("stall.rsp_rdata", rsp_rdata, 32'h55AA55AA);
    checkOutput("stall.rsp_err", 32'(rsp_err), 32'h0);
`endif

    // Reset during ACCESS must drop the bus at once and restore the arbitration pointer.
    cycle();
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
    checkOutput("rst.req_ready", 32'(req_ready), 32'h1);
    cycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    cycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("rst.pre_penable", 32'(penable), 32'h1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst.async_psel", 32'(psel), 32'h0);
    checkOutput("rst.async_penable", 32'(penable), 32'h0);
    checkOutput("rst.async_paddr", paddr, 32'h0);
    checkOutput("rst.async_pwdata", pwdata, 32'h0);
    cycle();
    cycle();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("rst.after%0d.rsp_valid", k), 32'(rsp_valid), 32'h0);
      checkOutput($sformatf("rst.after%0d.psel", k), 32'(psel), 32'h0);
    end
    cycle();
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("rst.tie_req_ready", 32'(req_ready), 32'h1);
    cycle();
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
    checkOutput("rst.tie_paddr", paddr, A0);
    checkOutput("rst.tie_psel", 32'(psel), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
